// File: rtl/tp84_snd_mixer_if.sv
// Mixer channel/gain inputs and sample outputs bundled as one port.
// The mute signal exists only when TP84_MIX_SOFTMUTE_EN is defined.
interface tp84_snd_mixer_if #(
    parameter int unsigned NUM_CH = 4
);
    logic [NUM_CH*8-1:0] ch_in;
    logic [NUM_CH*8-1:0] ch_gain;
    logic signed [15:0]  out;
    logic                out_valid;
    logic                busy;
`ifdef TP84_MIX_SOFTMUTE_EN
    logic                mute;
`endif

    modport master (
`ifdef TP84_MIX_SOFTMUTE_EN
        output mute,
`endif
        output ch_in, ch_gain,
        input  out, out_valid, busy
    );

    modport slave (
`ifdef TP84_MIX_SOFTMUTE_EN
        input  mute,
`endif
        input  ch_in, ch_gain,
        output out, out_valid, busy
    );
endinterface

// File: rtl/tp84_snd_mixer.sv
// Time-multiplexed MAC sound mixer: one sample per DIV clocks, saturated to signed 16 bit.
// Optional soft-mute attenuator enabled by defining TP84_MIX_SOFTMUTE_EN.
module tp84_snd_mixer #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DIV    = 256,
    parameter int          SHIFT  = 1
) (
    input logic             clk,
    input logic             reset,
    tp84_snd_mixer_if.slave mix
);
    localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IdxW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int          Sh   = 6 + SHIFT;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAcc  = 2'd1;
    localparam logic [1:0] StOut  = 2'd2;

    localparam logic signed [19:0] SatMax = 20'sd32767;
    localparam logic signed [19:0] SatMin = -20'sd32768;

    logic [CntW-1:0]              div_cnt_q;
    logic                         tick;
    logic [1:0]                   state_q, state_d;
    logic [IdxW-1:0]              idx_q, idx_d;
    logic signed [19:0]           acc_q, acc_d;
    logic [NUM_CH-1:0][7:0]       ch_sh_q, ch_sh_d;
    logic [NUM_CH-1:0][7:0]       gain_sh_q, gain_sh_d;
    logic signed [15:0]           out_q, out_d;
    logic                         valid_q, valid_d;

    logic signed [8:0]            centred;
    logic signed [16:0]           prod;
    logic signed [19:0]           shifted;
    logic signed [15:0]           clamped;
    logic signed [15:0]           result;

    assign tick = (div_cnt_q == CntW'(DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt_q <= '0;
        end else if (tick) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
        end
    end

    assign centred = $signed({1'b0, ch_sh_q[idx_q]}) - 9'sd128;
    assign prod    = centred * $signed({1'b0, gain_sh_q[idx_q]});
    assign shifted = acc_q >>> Sh;

    always_comb begin
        if (shifted > SatMax) begin
            clamped = 16'sh7fff;
        end else if (shifted < SatMin) begin
            clamped = -16'sh8000;
        end else begin
            clamped = shifted[15:0];
        end
    end

`ifdef TP84_MIX_SOFTMUTE_EN
    logic [6:0]         att_q, att_d;
    logic signed [23:0] scaled;
    logic signed [23:0] scaled_sh;

    // Attenuation ramps one step per sample period, so a full fade spans 64 samples.
    always_comb begin
        att_d = att_q;
        if (tick) begin
            if (mix.mute && att_q != 7'd0) begin
                att_d = att_q - 7'd1;
            end else if (!mix.mute && att_q != 7'd64) begin
                att_d = att_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            att_q <= 7'd64;
        end else begin
            att_q <= att_d;
        end
    end

    assign scaled    = clamped * $signed({1'b0, att_q});
    assign scaled_sh = scaled >>> 6;
    assign result    = scaled_sh[15:0];
`else
    assign result = clamped;
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        ch_sh_d   = ch_sh_q;
        gain_sh_d = gain_sh_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (tick) begin
                    ch_sh_d   = mix.ch_in;
                    gain_sh_d = mix.ch_gain;
                    acc_d     = '0;
                    idx_d     = '0;
                    state_d   = StAcc;
                end
            end
            StAcc: begin
                acc_d = acc_q + {{3{prod[16]}}, prod};
                idx_d = idx_q + 1'b1;
                if (idx_q == IdxW'(NUM_CH - 1)) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                out_d   = result;
                valid_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            acc_q     <= '0;
            ch_sh_q   <= '0;
            gain_sh_q <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            ch_sh_q   <= ch_sh_d;
            gain_sh_q <= gain_sh_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
        end
    end

    assign mix.out       = out_q;
    assign mix.out_valid = valid_q;
    assign mix.busy      = (state_q != StIdle);
endmodule
